// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - opcode, funct3/funct7 constants and FSM state type for core_v2
package core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/regf_p.sv
// rtl/regf_p.sv - register file, 2 async read ports, 1 sync write port
// Ports:
//   clk, rst           clock, async active-high reset (clears every register)
//   raddr_a/rdata_a    read port A (x0 and out-of-range addresses read 0)
//   raddr_b/rdata_b    read port B
//   we/waddr/wdata     write port; writes to x0 or out-of-range addresses dropped
module regf_p
    import core_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    logic [31:0] regs_q [NUM_REGS];

    logic a_ok, b_ok, w_ok;
    assign a_ok = (raddr_a != 5'd0) && ({1'b0, raddr_a} < NREGS);
    assign b_ok = (raddr_b != 5'd0) && ({1'b0, raddr_b} < NREGS);
    assign w_ok = (waddr   != 5'd0) && ({1'b0, waddr}   < NREGS);

    assign rdata_a = a_ok ? regs_q[raddr_a[AW-1:0]] : 32'd0;
    assign rdata_b = b_ok ? regs_q[raddr_b[AW-1:0]] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we && w_ok) begin
            regs_q[waddr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/core_v2.sv
// rtl/core_v2.sv - multi-cycle RV32I/E integer core (FETCH/EXEC/HALT)
// Ports:
//   clk, rst               clock, async active-high reset
//   imem_req/imem_addr     fetch request and byte address (= pc)
//   imem_ack/imem_rdata    fetch data valid and instruction word
//   last_pc                address of the final instruction of the stream
//   halted, error          core stopped / stopped on illegal or misaligned target
//   instret                retired-instruction count
module core_v2
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] last_pc,
    output logic        halted,
    output logic        error,
    output logic [31:0] instret
);

    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    state_e      state_q;
    logic [31:0] pc_q, ir_q, instret_q;
    logic        halted_q, error_q;

    // Instruction fields
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'd0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    logic [31:0] rs1_v, rs2_v;
    logic        rf_we;
    logic [31:0] rf_wdata;

    regf_p #(.NUM_REGS(NUM_REGS)) u_regf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs1),
        .rdata_a (rs1_v),
        .raddr_b (rs2),
        .rdata_b (rs2_v),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata)
    );

    // ALU: OP uses rs2, OP-IMM uses imm_i; only OP can subtract
    logic        is_op;
    logic [31:0] op_b, alu_res;
    logic [4:0]  shamt;
    assign is_op = (opc == OPC_OP);
    assign op_b  = is_op ? rs2_v : imm_i;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (f3)
            F3_ADD:  alu_res = (is_op && f7[5]) ? rs1_v - op_b : rs1_v + op_b;
            F3_SLL:  alu_res = rs1_v << shamt;
            F3_SLT:  alu_res = {31'd0, $signed(rs1_v) < $signed(op_b)};
            F3_SLTU: alu_res = {31'd0, rs1_v < op_b};
            F3_XOR:  alu_res = rs1_v ^ op_b;
            F3_SR:   alu_res = f7[5] ? 32'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            F3_OR:   alu_res = rs1_v | op_b;
            F3_AND:  alu_res = rs1_v & op_b;
            default: alu_res = 32'd0;
        endcase
    end

    // Branch compare
    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (f3)
            F3_BEQ:  br_taken = (rs1_v == rs2_v);
            F3_BNE:  br_taken = (rs1_v != rs2_v);
            F3_BLT:  br_taken = ($signed(rs1_v) <  $signed(rs2_v));
            F3_BGE:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
            F3_BLTU: br_taken = (rs1_v <  rs2_v);
            F3_BGEU: br_taken = (rs1_v >= rs2_v);
            default: br_taken = 1'b0;
        endcase
    end

    // Decode: legality, register usage, next pc and write-back value
    logic        legal_op, uses_rs1, uses_rs2, uses_rd, redirect;
    logic [31:0] npc, wb_val, pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        legal_op = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        redirect = 1'b0;
        npc      = pc_plus4;
        wb_val   = alu_res;
        case (opc)
            OPC_OP: begin
                legal_op = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL)     legal_op = (f7 == F7_BASE);
                else if (f3 == F3_SR) legal_op = (f7 == F7_BASE) || (f7 == F7_ALT);
                else                  legal_op = 1'b1;
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            OPC_LUI: begin
                legal_op = 1'b1;
                uses_rd  = 1'b1;
                wb_val   = imm_u;
            end
            OPC_AUIPC: begin
                legal_op = 1'b1;
                uses_rd  = 1'b1;
                wb_val   = pc_q + imm_u;
            end
            OPC_JAL: begin
                legal_op = 1'b1;
                uses_rd  = 1'b1;
                redirect = 1'b1;
                npc      = pc_q + imm_j;
                wb_val   = pc_plus4;
            end
            OPC_JALR: begin
                legal_op = (f3 == 3'd0);
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
                redirect = 1'b1;
                npc      = (rs1_v + imm_i) & ~32'd1;
                wb_val   = pc_plus4;
            end
            OPC_BRANCH: begin
                legal_op = (f3 != 3'd2) && (f3 != 3'd3);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                redirect = br_taken;
                npc      = br_taken ? pc_q + imm_b : pc_plus4;
            end
            default: legal_op = 1'b0;
        endcase
    end

    logic regs_ok, misaligned, illegal;
    assign regs_ok = !(uses_rs1 && ({1'b0, rs1} >= NREGS)) &&
                     !(uses_rs2 && ({1'b0, rs2} >= NREGS)) &&
                     !(uses_rd  && ({1'b0, rd}  >= NREGS));
    assign misaligned = redirect && (npc[1:0] != 2'b00);
    assign illegal    = !legal_op || !regs_ok || misaligned;

    assign rf_we    = (state_q == ST_EXEC) && !illegal && uses_rd;
    assign rf_wdata = wb_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            instret_q <= 32'd0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Error wins over reaching last_pc
                    if (illegal) begin
                        error_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        pc_q      <= npc;
                        instret_q <= instret_q + 32'd1;
                        if (pc_q == last_pc) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            state_q  <= ST_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign halted    = halted_q;
    assign error     = error_q;
    assign instret   = instret_q;

endmodule
